cnn_argmax_classifier: RTL and testbench

- Final classification stage of the CNN accelerator. Consumes the per-class logit stream from the last fully-connected layer and tracks the running signed maximum.
- Emits a 4-bit class index with a one-cycle done pulse. These drive class_in/cnn_done of the differential-privacy noise injector directly downstream.
- Also flags frames whose logit count does not match NUM_CLASSES.

---
 rtl/cnn_argmax_classifier.sv | 151 +++++++++++++++
 tb/tb_cnn_argmax_classifier.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_argmax_classifier.sv
// Argmax over a frame of signed logits, with a one-cycle done pulse and a sticky frame-length error.
// Optional ARGMAX_MARGIN_EN adds margin_out, the saturated best-minus-second-best gap.
module cnn_argmax_classifier #(
  parameter int NUM_CLASSES = 10,
  parameter int LOGIT_W     = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               logit_valid,
  output logic               logit_ready,
  input  logic [LOGIT_W-1:0] logit_data,
  input  logic               logit_last,
  output logic [3:0]         class_out,
  output logic [LOGIT_W-1:0] max_logit,
  output logic               cnn_done,
  output logic               busy,
`ifdef ARGMAX_MARGIN_EN
  output logic [LOGIT_W-1:0] margin_out,
`endif
  output logic               count_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);
  localparam logic [LOGIT_W-1:0] MIN_VAL = {1'b1, {(LOGIT_W-1){1'b0}}};

  state_t             state_q, state_d;
  logic [3:0]         count_q, count_d;
  logic [LOGIT_W-1:0] best_q, best_d;
  logic [3:0]         idx_q, idx_d;
  logic [3:0]         class_q, class_d;
  logic [LOGIT_W-1:0] max_q, max_d;
  logic               err_q, err_d;
  logic               hs, greater, at_end;
`ifdef ARGMAX_MARGIN_EN
  logic [LOGIT_W-1:0] second_q, second_d;
  logic [LOGIT_W-1:0] margin_q, margin_d;
  logic [LOGIT_W:0]   diff;
`endif

  assign logit_ready = (state_q == S_COLLECT);
  assign busy        = (state_q != S_IDLE);
  assign cnn_done    = (state_q == S_DONE);
  assign class_out   = class_q;
  assign max_logit   = max_q;
  assign count_err   = err_q;
`ifdef ARGMAX_MARGIN_EN
  assign margin_out  = margin_q;
`endif

  // Next-state, running max and frame-end result capture.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    best_d  = best_q;
    idx_d   = idx_q;
    class_d = class_q;
    max_d   = max_q;
    err_d   = err_q;
    hs      = logit_valid & logit_ready;
    greater = $signed(logit_data) > $signed(best_q);
    at_end  = (count_q == LAST_IDX);
`ifdef ARGMAX_MARGIN_EN
    second_d = second_q;
    margin_d = margin_q;
    diff     = '0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_COLLECT;
          count_d = '0;
          best_d  = MIN_VAL;
          idx_d   = '0;
          err_d   = 1'b0;
`ifdef ARGMAX_MARGIN_EN
          second_d = MIN_VAL;
`endif
        end
      end
      S_COLLECT: begin
        if (hs) begin
          if (greater) begin
            best_d = logit_data;
            idx_d  = count_q;
          end
`ifdef ARGMAX_MARGIN_EN
          if (greater) begin
            second_d = best_q;
          end else if ($signed(logit_data) > $signed(second_q)) begin
            second_d = logit_data;
          end
`endif
          count_d = count_q + 4'd1;
          if (logit_last | at_end) begin
            class_d = idx_d;
            max_d   = best_d;
            err_d   = logit_last ^ at_end;
            state_d = S_DONE;
`ifdef ARGMAX_MARGIN_EN
            diff = {best_d[LOGIT_W-1], best_d}
                 - {second_d[LOGIT_W-1], second_d};
            if (count_q == 4'd0 || diff[LOGIT_W])
              margin_d = '1;
            else
              margin_d = diff[LOGIT_W-1:0];
`endif
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      count_q <= '0;
      best_q  <= MIN_VAL;
      idx_q   <= '0;
      class_q <= '0;
      max_q   <= '0;
      err_q   <= 1'b0;
`ifdef ARGMAX_MARGIN_EN
      second_q <= MIN_VAL;
      margin_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      best_q  <= best_d;
      idx_q   <= idx_d;
      class_q <= class_d;
      max_q   <= max_d;
      err_q   <= err_d;
`ifdef ARGMAX_MARGIN_EN
      second_q <= second_d;
      margin_q <= margin_d;
`endif
    end
  end

endmodule

// File: tb/tb_cnn_argmax_classifier.sv
// Directed bench for cnn_argmax_classifier.
// Define ARGMAX_MARGIN_EN to also exercise margin_out.
module tb_cnn_argmax_classifier;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        logit_valid = 1'b0;
  logic        logit_ready;
  logic [15:0] logit_data = '0;
  logic        logit_last = 1'b0;
  logic [3:0]  class_out;
  logic [15:0] max_logit;
  logic        cnn_done;
  logic        busy;
  logic        count_err;
`ifdef ARGMAX_MARGIN_EN
  logic [15:0] margin_out;
`endif

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int done_ref;
  bit ok;
  int q[$];
  logic [15:0] vec [16];

  cnn_argmax_classifier #(.NUM_CLASSES(10), .LOGIT_W(16)) dut (
    .clk(clk),
    .resetn(resetn),
    .start(start),
    .logit_valid(logit_valid),
    .logit_ready(logit_ready),
    .logit_data(logit_data),
    .logit_last(logit_last),
    .class_out(class_out),
    .max_logit(max_logit),
    .cnn_done(cnn_done),
    .busy(busy),
`ifdef ARGMAX_MARGIN_EN
    .margin_out(margin_out),
`endif
    .count_err(count_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (cnn_done) done_cnt <= done_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_q();
    foreach (q[i]) vec[i] = 16'(q[i]);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit use_last,
                            input bit gaps, input int inj_start,
                            output bit done_ok);
    int i = 0;
    int cyc = 0;
    bit hs;
    while (i < n && cyc < 300) begin
      @(negedge clk);
      start = (cyc == inj_start);
      logit_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      logit_data = vec[i];
      logit_last = use_last && (i == n - 1);
      hs = logit_valid && logit_ready;
      @(posedge clk);
      if (hs) i++;
      cyc++;
    end
    #1;
    start = 1'b0;
    logit_valid = 1'b0;
    logit_last = 1'b0;
    done_ok = (i == n);
  endtask

  task automatic end_checks(input string tag, input logic [3:0] ecls,
                            input logic [15:0] emax, input logic eerr);
    chk({tag, "_done_pulse"}, cnn_done, 1);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_ready_low"}, logit_ready, 0);
    chk({tag, "_class"}, class_out, ecls);
    chk({tag, "_max"}, max_logit, emax);
    chk({tag, "_err"}, count_err, eerr);
    @(posedge clk);
    #1;
    chk({tag, "_done_low"}, cnn_done, 0);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_class_hold"}, class_out, ecls);
    chk({tag, "_one_done"}, done_cnt - done_ref, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_class", class_out, 0);
    chk("rst_max", max_logit, 0);
    chk("rst_done", cnn_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", logit_ready, 0);
    chk("rst_err", count_err, 0);
    @(negedge clk) resetn = 1'b1;

    // Basic frame, no gaps.
    q = '{3, -1, 7, 7, 2, 0, -5, 1, 6, 4};
    load_q();
    done_ref = done_cnt;
    do_start();
    chk("t1_busy", busy, 1);
    send_frame(10, 1, 0, -1, ok);
    chk("t1_budget", ok, 1);
    end_checks("t1", 4'd2, 16'd7, 1'b0);

    // All logits at the minimum value.
    for (int i = 0; i < 10; i++) vec[i] = 16'h8000;
    done_ref = done_cnt;
    do_start();
    send_frame(10, 1, 0, -1, ok);
    chk("t2_budget", ok, 1);
    end_checks("t2", 4'd0, 16'h8000, 1'b0);

    // Same as the first frame with random gaps and a stray start.
    q = '{3, -1, 7, 7, 2, 0, -5, 1, 6, 4};
    load_q();
    done_ref = done_cnt;
    do_start();
    send_frame(10, 1, 1, 3, ok);
    chk("t3_budget", ok, 1);
    end_checks("t3", 4'd2, 16'd7, 1'b0);
    repeat (3) @(posedge clk);
    #1 chk("t3_no_extra_done", done_cnt - done_ref, 1);

    // Early last.
    q = '{1, 2, 9, 3, 4, 5};
    load_q();
    done_ref = done_cnt;
    do_start();
    send_frame(6, 1, 0, -1, ok);
    chk("t4_budget", ok, 1);
    end_checks("t4", 4'd2, 16'd9, 1'b1);
    do_start();
    chk("t4_err_cleared", count_err, 0);

    // Missing last: frame forced to end at the tenth sample.
    q = '{-10, -20, -5, -30, -1, -40, -2, -50, -60, -70};
    load_q();
    done_ref = done_cnt;
    send_frame(10, 0, 0, -1, ok);
    chk("t5_budget", ok, 1);
    end_checks("t5", 4'd4, 16'hFFFF, 1'b1);

    // Reset mid-frame, then a clean frame.
    for (int i = 0; i < 4; i++) vec[i] = 16'd100;
    done_ref = done_cnt;
    do_start();
    send_frame(4, 0, 0, -1, ok);
    @(negedge clk) resetn = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_rst_class", class_out, 0);
    chk("t6_rst_max", max_logit, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_err", count_err, 0);
    chk("t6_no_done", done_cnt - done_ref, 0);
    @(negedge clk) resetn = 1'b1;
    q = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 5};
    load_q();
    do_start();
    send_frame(10, 1, 0, -1, ok);
    chk("t6_budget", ok, 1);
    end_checks("t6", 4'd9, 16'd5, 1'b0);

`ifdef ARGMAX_MARGIN_EN
    q = '{10, 4, -3, 4, 0, 0, 0, 0, 0, 0};
    load_q();
    done_ref = done_cnt;
    do_start();
    send_frame(10, 1, 0, -1, ok);
    chk("m1_margin", margin_out, 16'd6);
    end_checks("m1", 4'd0, 16'd10, 1'b0);

    q = '{32767, -32768, -32768, -32768, -32768,
          -32768, -32768, -32768, -32768, -32768};
    load_q();
    done_ref = done_cnt;
    do_start();
    send_frame(10, 1, 0, -1, ok);
    chk("m2_margin", margin_out, 16'hFFFF);
    end_checks("m2", 4'd0, 16'h7FFF, 1'b0);

    vec[0] = 16'd0;
    done_ref = done_cnt;
    do_start();
    send_frame(1, 1, 0, -1, ok);
    chk("m3_margin", margin_out, 16'hFFFF);
    end_checks("m3", 4'd0, 16'd0, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
